// File: rtl/seg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_scanner
// Description : Time-multiplexed seven-segment driver with per-digit blank and
//               blink, 16-level PWM brightness and frame-synchronous latching.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_scanner #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 12500,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   number,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [3:0]            brightness,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [7:0]            segment,
    output logic                  frame_start
);

    localparam int STEP  = SCAN_DIV / 16;
    localparam int SUB_W = (STEP > 1) ? $clog2(STEP) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [3:0]       PWM_LAST = 4'hF;

    // Slot position is kept as {r_pwm, r_sub}: slot_cnt = r_pwm*STEP + r_sub,
    // so the PWM phase falls out directly without a divider.
    logic [SUB_W-1:0]    r_sub;
    logic [3:0]          r_pwm;
    logic [IDX_W-1:0]    r_idx;
    logic [BLK_W-1:0]    r_blk;
    logic                r_blink_phase;

    logic [4*DIGITS-1:0] r_num;
    logic [DIGITS-1:0]   r_dp;
    logic [DIGITS-1:0]   r_blank;
    logic [DIGITS-1:0]   r_blink;
    logic [3:0]          r_bri;

    logic                w_sub_wrap;
    logic                w_slot_wrap;
    logic                w_frame_wrap;
    logic                w_blink_wrap;
    logic                w_latch;

    logic [4*DIGITS-1:0] w_num;
    logic [DIGITS-1:0]   w_dp;
    logic [DIGITS-1:0]   w_blank;
    logic [DIGITS-1:0]   w_blink;
    logic [3:0]          w_bri;

    logic [3:0]          w_nib;
    logic [6:0]          w_glyph;
    logic [DIGITS-1:0]   w_onehot;
    logic                w_lit;
    logic                w_dark;

    assign w_sub_wrap   = (r_sub == SUB_LAST);
    assign w_slot_wrap  = w_sub_wrap && (r_pwm == PWM_LAST);
    assign w_frame_wrap = w_slot_wrap && (r_idx == IDX_LAST);
    assign w_blink_wrap = w_frame_wrap && (r_blk == BLK_LAST);
    assign w_latch      = (r_idx == '0) && (r_pwm == 4'd0) && (r_sub == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sub         <= '0;
            r_pwm         <= 4'd0;
            r_idx         <= '0;
            r_blk         <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_sub <= w_sub_wrap ? '0 : r_sub + 1'b1;
            if (w_sub_wrap) begin
                r_pwm <= r_pwm + 4'd1;
            end
            if (w_slot_wrap) begin
                r_idx <= w_frame_wrap ? '0 : r_idx + 1'b1;
            end
            if (w_frame_wrap) begin
                r_blk <= w_blink_wrap ? '0 : r_blk + 1'b1;
            end
            if (w_blink_wrap) begin
                r_blink_phase <= ~r_blink_phase;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_num   <= '0;
            r_dp    <= '0;
            r_blank <= '0;
            r_blink <= '0;
            r_bri   <= 4'd0;
        end else if (w_latch) begin
            r_num   <= number;
            r_dp    <= dp;
            r_blank <= blank_mask;
            r_blink <= blink_mask;
            r_bri   <= brightness;
        end
    end

    // On the latch cycle the shadows are still stale, so decode from the live
    // inputs; every cycle of the frame then sees the same snapshot.
    assign w_num   = w_latch ? number     : r_num;
    assign w_dp    = w_latch ? dp         : r_dp;
    assign w_blank = w_latch ? blank_mask : r_blank;
    assign w_blink = w_latch ? blink_mask : r_blink;
    assign w_bri   = w_latch ? brightness : r_bri;

    assign w_nib    = w_num[{r_idx, 2'b00} +: 4];
    assign w_onehot = DIGITS'(1) << r_idx;
    assign w_lit    = (r_pwm <= w_bri);

    always_comb begin
        w_glyph = 7'h00;
        case (w_nib)
            4'h0: w_glyph = 7'h3F;
            4'h1: w_glyph = 7'h06;
            4'h2: w_glyph = 7'h5B;
            4'h3: w_glyph = 7'h4F;
            4'h4: w_glyph = 7'h66;
            4'h5: w_glyph = 7'h6D;
            4'h6: w_glyph = 7'h7D;
            4'h7: w_glyph = 7'h07;
            4'h8: w_glyph = 7'h7F;
            4'h9: w_glyph = 7'h6F;
            4'hA: w_glyph = 7'h77;
            4'hB: w_glyph = 7'h7C;
            4'hC: w_glyph = 7'h39;
            4'hD: w_glyph = 7'h5E;
            4'hE: w_glyph = 7'h79;
            4'hF: w_glyph = 7'h71;
            default: w_glyph = 7'h00;
        endcase
    end

    // The final cycle of each slot is always dark so two digits are never
    // driven back to back.
    assign w_dark = !enable
                  || w_blank[r_idx]
                  || (w_blink[r_idx] && r_blink_phase)
                  || !w_lit
                  || w_slot_wrap;

    always_ff @(posedge clock) begin
        if (reset) begin
            digit_sel   <= '0;
            segment     <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            digit_sel   <= w_dark ? '0 : w_onehot;
            segment     <= w_dark ? 8'h00 : {w_dp[r_idx], w_glyph};
            frame_start <= w_latch;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_scanner
// Description : Self-checking bench: cycle-level reference model feeding a
//               scoreboard, plus directed checks against fixed glyph values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_scanner;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 32;
    localparam int BLINK_FRAMES = 2;
    localparam int STEP         = SCAN_DIV / 16;
    localparam int FRAME        = DIGITS * SCAN_DIV;

    bit          clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] number;
    logic [3:0]  dp;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [3:0]  brightness;
    logic [3:0]  digit_sel;
    logic [7:0]  segment;
    logic        frame_start;

    int chk_cnt = 0;
    int err_cnt = 0;

    logic [12:0] exp_q[$];

    seg_display_scanner #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .number      (number),
        .dp          (dp),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .brightness  (brightness),
        .digit_sel   (digit_sel),
        .segment     (segment),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    // Reference model: free-running cycle counters, pushes the expected
    // {digit_sel, segment, frame_start} for every clock edge.
    int          m_slot, m_idx, m_bcnt;
    logic        m_bph;
    logic [15:0] sh_num;
    logic [3:0]  sh_dp, sh_blank, sh_blink, sh_bri;
    logic        m_latch, m_dark;
    logic [12:0] m_exp;

    always @(posedge clock) begin
        if (reset) begin
            m_slot = 0; m_idx = 0; m_bcnt = 0; m_bph = 1'b0;
            sh_num = '0; sh_dp = '0; sh_blank = '0; sh_blink = '0; sh_bri = '0;
            exp_q.push_back(13'd0);
        end else begin
            m_latch = (m_idx == 0) && (m_slot == 0);
            if (m_latch) begin
                sh_num = number; sh_dp = dp; sh_blank = blank_mask;
                sh_blink = blink_mask; sh_bri = brightness;
            end
            m_dark = !enable || sh_blank[m_idx] || (sh_blink[m_idx] && m_bph)
                     || ((m_slot / STEP) > int'(sh_bri)) || (m_slot == SCAN_DIV - 1);
            if (m_dark)
                m_exp = {4'b0000, 8'h00, m_latch};
            else
                m_exp = {4'(1 << m_idx), sh_dp[m_idx], hex7(sh_num[m_idx*4 +: 4]), m_latch};
            exp_q.push_back(m_exp);
            m_slot++;
            if (m_slot == SCAN_DIV) begin
                m_slot = 0;
                m_idx++;
                if (m_idx == DIGITS) begin
                    m_idx = 0;
                    m_bcnt++;
                    if (m_bcnt == BLINK_FRAMES) begin
                        m_bcnt = 0;
                        m_bph = !m_bph;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [12:0] e;
            e = exp_q.pop_front();
            check_eq("scan", {19'd0, digit_sel, segment, frame_start}, {19'd0, e});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_frame(input int budget);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_start && n < budget);
        check_eq("frame_wait", 32'(frame_start), 32'd1);
    endtask

    task automatic count_lit(input string tag, input int exp);
        int lit = 0;
        for (int i = 0; i < SCAN_DIV; i++) begin
            if (digit_sel != 4'b0000) lit++;
            tick(1);
        end
        check_eq(tag, lit, exp);
    endtask

    initial begin
        int   seen3;
        reset = 1'b1; enable = 1'b0; number = '0; dp = '0;
        blank_mask = '0; blink_mask = '0; brightness = '0;
        tick(3);
        check_eq("rst_sel", 32'(digit_sel), 32'd0);
        check_eq("rst_seg", 32'(segment), 32'd0);
        check_eq("rst_fs", 32'(frame_start), 32'd0);

        // Basic scan
        number = 16'h08A1; brightness = 4'd15; enable = 1'b1; reset = 1'b0;
        wait_frame(8);
        check_eq("d0", {20'd0, digit_sel, segment}, {20'd0, 4'b0001, 8'h06});
        tick(31);
        check_eq("gap", 32'(digit_sel), 32'd0);
        tick(1);
        check_eq("d1", {20'd0, digit_sel, segment}, {20'd0, 4'b0010, 8'h77});
        tick(32);
        check_eq("d2", {20'd0, digit_sel, segment}, {20'd0, 4'b0100, 8'h7F});
        tick(32);
        check_eq("d3", {20'd0, digit_sel, segment}, {20'd0, 4'b1000, 8'h3F});
        tick(32);
        check_eq("period", 32'(frame_start), 32'd1);

        // Tear-free latch: change mid-frame during digit 1
        tick(40);
        number = 16'hFFFF;
        tick(24);
        check_eq("tear_d2", {20'd0, digit_sel, segment}, {20'd0, 4'b0100, 8'h7F});
        tick(32);
        check_eq("tear_d3", {20'd0, digit_sel, segment}, {20'd0, 4'b1000, 8'h3F});
        tick(32);
        check_eq("new_d0", {20'd0, digit_sel, segment}, {20'd0, 4'b0001, 8'h71});
        tick(32);
        check_eq("new_d1", {20'd0, digit_sel, segment}, {20'd0, 4'b0010, 8'h71});

        // Brightness
        brightness = 4'd0;
        wait_frame(2 * FRAME);
        count_lit("bri0_lit", 2);
        brightness = 4'd7;
        wait_frame(2 * FRAME);
        count_lit("bri7_lit", 16);

        // Decimal point and enable drop
        brightness = 4'd15; dp = 4'b0100; number = 16'h08A1;
        wait_frame(2 * FRAME);
        tick(64);
        check_eq("dp", {20'd0, digit_sel, segment}, {20'd0, 4'b0100, 8'hFF});
        tick(10);
        enable = 1'b0;
        tick(1);
        check_eq("en_off_first", 32'(digit_sel), 32'd0);
        tick(4);
        check_eq("en_off_last", 32'(digit_sel), 32'd0);
        enable = 1'b1;
        tick(1);
        check_eq("en_back", {20'd0, digit_sel, segment}, {20'd0, 4'b0100, 8'hFF});

        // Blink and blank, aligned to a fresh reset
        dp = 4'b0000; blink_mask = 4'b0001; blank_mask = 4'b1000;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        wait_frame(8);
        seen3 = 0;
        for (int f = 0; f < 6; f++) begin
            check_eq($sformatf("blink_f%0d", f), 32'(digit_sel[0]),
                     (f == 2 || f == 3) ? 32'd0 : 32'd1);
            for (int c = 0; c < FRAME; c++) begin
                if (digit_sel[3]) seen3++;
                tick(1);
            end
        end
        check_eq("blank3", seen3, 0);

        // Reset in the middle of digit 2
        blink_mask = '0; blank_mask = '0;
        wait_frame(2 * FRAME);
        tick(70);
        reset = 1'b1;
        tick(1);
        check_eq("midrst_sel", 32'(digit_sel), 32'd0);
        check_eq("midrst_seg", 32'(segment), 32'd0);
        check_eq("midrst_fs", 32'(frame_start), 32'd0);
        reset = 1'b0;
        tick(1);
        check_eq("restart_fs", 32'(frame_start), 32'd1);
        check_eq("restart_sel", 32'(digit_sel), 32'd1);
        tick(40);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
